// File: rtl/seq_shifter_pkg.sv
// Shared constants and FSM encoding for the sequential barrel-free shifter.
package seq_shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT4 = 2'd1,
        SHIFT1 = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Where to go given the shift distance still outstanding.
    function automatic state_t next_state(input logic [SHAMT_W-1:0] rem);
        if (rem >= SHAMT_W'(4))
            return SHIFT4;
        else if (rem != '0)
            return SHIFT1;
        else
            return DONE;
    endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift step of 4 or 1 bit positions in the requested direction/mode.
module shift_step
    import seq_shifter_pkg::*;
(
    input  logic [DATA_W-1:0] val,
    input  logic              op,
    input  logic              sra,
    input  logic              rotate,
    input  logic              step4,
    output logic [DATA_W-1:0] nxt
);

    logic fill;

    // Sign fill only for arithmetic right shifts; a left shift with sra set stays logical.
    assign fill = op & sra & ~rotate & val[DATA_W-1];

    always_comb begin
        nxt = val;
        if (step4) begin
            if (rotate)
                nxt = op ? {val[3:0], val[DATA_W-1:4]} : {val[DATA_W-5:0], val[DATA_W-1:DATA_W-4]};
            else
                nxt = op ? {{4{fill}}, val[DATA_W-1:4]} : {val[DATA_W-5:0], 4'b0000};
        end else begin
            if (rotate)
                nxt = op ? {val[0], val[DATA_W-1:1]} : {val[DATA_W-2:0], val[DATA_W-1]};
            else
                nxt = op ? {fill, val[DATA_W-1:1]} : {val[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: consumes the shift amount in steps of 4, then steps of 1,
// with a valid/ready request side and a valid/ready result side.
module seq_shifter
    import seq_shifter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic        op,
    input  logic        sra,
    input  logic        rotate,
    output logic [31:0] result,
    output logic        done_valid,
    input  logic        done_ready,
    output logic        busy
);

    state_t              state;
    logic [DATA_W-1:0]   work;
    logic [SHAMT_W-1:0]  rem;
    logic                op_q;
    logic                sra_q;
    logic                rot_q;

    logic                step4;
    logic [DATA_W-1:0]   step_val;
    logic [SHAMT_W-1:0]  rem_nxt;

    assign step4   = (state == SHIFT4);
    assign rem_nxt = step4 ? rem - SHAMT_W'(4) : rem - SHAMT_W'(1);

    shift_step u_step (
        .val    (work),
        .op     (op_q),
        .sra    (sra_q),
        .rotate (rot_q),
        .step4  (step4),
        .nxt    (step_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            work        <= '0;
            rem         <= '0;
            op_q        <= 1'b0;
            sra_q       <= 1'b0;
            rot_q       <= 1'b0;
            result      <= '0;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // start_ready is low on the first edge out of reset, so no accept there.
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        work        <= a;
                        rem         <= shamt;
                        op_q        <= op;
                        sra_q       <= sra;
                        rot_q       <= rotate;
                        state       <= next_state(shamt);
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (shamt == '0) begin
                            result     <= a;
                            done_valid <= 1'b1;
                        end
                    end
                end
                SHIFT4, SHIFT1: begin
                    work  <= step_val;
                    rem   <= rem_nxt;
                    state <= next_state(rem_nxt);
                    if (rem_nxt == '0) begin
                        result     <= step_val;
                        done_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized and directed bench for seq_shifter against an arithmetic shift model.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        op;
    logic        sra;
    logic        rotate;
    logic [31:0] result;
    logic        done_valid;
    logic        done_ready;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    seq_shifter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .shamt       (shamt),
        .op          (op),
        .sra         (sra),
        .rotate      (rotate),
        .result      (result),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s,
                                              input logic opv, input logic srav, input logic rotv);
        if (rotv) begin
            if (s == 0) return x;
            return opv ? ((x >> s) | (x << (32 - s))) : ((x << s) | (x >> (32 - s)));
        end
        if (!opv) return x << s;
        if (srav) return $unsigned($signed(x) >>> s);
        return x >> s;
    endfunction

    // Issues one request, waits for the result, checks value, latency and ready timing.
    task automatic run_req(input string tag, input logic [31:0] ai, input logic [4:0] si,
                           input logic opi, input logic srai, input logic roti, input bit leave);
        logic [31:0] exp;
        int exp_lat;
        int lat;
        int low;
        int guard;
        exp     = ref_shift(ai, int'(si), opi, srai, roti);
        exp_lat = 1 + int'(si) / 4 + int'(si) % 4;
        guard = 0;
        while (!start_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, ".ready"}, 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a = ai; shamt = si; op = opi; sra = srai; rotate = roti;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom; shamt = 5'($urandom); op = 1'($urandom); sra = 1'($urandom); rotate = 1'($urandom);
        lat = 1;
        low = 0;
        while (1) begin
            if (!start_ready) low++;
            if (done_valid || lat >= 15) break;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".done"}, 32'(done_valid), 32'd1);
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".res"}, result, exp);
        if (leave) begin
            @(posedge clk); #1;
            chk({tag, ".lowcyc"}, 32'(low), 32'(exp_lat));
            chk({tag, ".idle_rdy"}, 32'(start_ready), 32'd1);
            chk({tag, ".idle_dv"}, 32'(done_valid), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b1;
        a = '0; shamt = '0; op = 1'b0; sra = 1'b0; rotate = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.result", result, 32'h0);
        chk("rst.outs", {29'd0, done_valid, busy, start_ready}, 32'd0);
        rst_n = 1'b1;
        start_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst.first_rdy", 32'(start_ready), 32'd1);
        chk("rst.no_accept", 32'(busy), 32'd0);
        start_valid = 1'b0;

        run_req("d_lsl4",   32'h12345678, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1);
        run_req("d_asr4",   32'h87654321, 5'd4,  1'b1, 1'b1, 1'b0, 1'b1);
        run_req("d_lsr5",   32'h80000000, 5'd5,  1'b1, 1'b0, 1'b0, 1'b1);
        run_req("d_ror8",   32'hFEDCBA98, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1);
        run_req("d_rol31",  32'h00000001, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1);
        run_req("d_lslsra", 32'h80000001, 5'd3,  1'b0, 1'b1, 1'b0, 1'b1);
        chk("d_const1", ref_shift(32'h87654321, 4, 1'b1, 1'b1, 1'b0), 32'hF8765432);

        // Zero shift with the consumer stalled.
        done_ready = 1'b0;
        run_req("d_zero", 32'hC0FFEE01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.res", result, 32'hC0FFEE01);
            chk("hold.dv", 32'(done_valid), 32'd1);
            chk("hold.rdy", 32'(start_ready), 32'd0);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold.release_dv", 32'(done_valid), 32'd0);
        chk("hold.release_rdy", 32'(start_ready), 32'd1);

        // Reset in the middle of a long request.
        start_valid = 1'b1; a = 32'hDEADBEEF; shamt = 5'd20; op = 1'b0; sra = 1'b0; rotate = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.busy_pre", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.result", result, 32'h0);
        chk("abort.outs", {29'd0, done_valid, busy, start_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("abort.no_dv", 32'(done_valid), 32'd0);
        end
        run_req("post_rst", 32'hA5A5F00F, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1);

        // Random back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            run_req("rand", 32'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 and shift amount width at 5.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  request present
- start_ready  out  1  block can accept a request
- a  in  32  operand
- shamt  in  5  shift amount, 0..31
- op  in  1  direction: 0 = left, 1 = right
- sra  in  1  arithmetic right shift; takes effect only when op=1 and rotate=0
- rotate  in  1  rotate; overrides sra
- result  out  32  shifted value
- done_valid  out  1  result valid
- done_ready  in  1  consumer takes the result
- busy  out  1  high in any state except IDLE

Function
REQ-004 SHALL accept a request on the rising edge where start_valid and start_ready are both high. On that edge it latches a, shamt, op, sra and rotate; later changes on those inputs are ignored.
REQ-005 SHALL drive start_ready high only in IDLE.
REQ-006 SHALL implement FSM states IDLE, SHIFT4, SHIFT1 and DONE.
REQ-007 SHALL take these transitions on the accept edge:
- remaining >= 4 -> SHIFT4
- remaining 1..3 -> SHIFT1
- remaining 0 -> DONE
REQ-008 SHALL, on each edge in SHIFT4, shift the working register by 4 and subtract 4 from remaining. The next state follows the rule in REQ-007.
REQ-009 SHALL, on each edge in SHIFT1, shift the working register by 1 and decrement remaining. The next state follows the rule in REQ-007.
REQ-010 SHALL apply these step semantics:
- left: zero fill
- right logical: zero fill
- right arithmetic: fill with bit 31 of the working register
- rotate: bits wrap in the selected direction
- op=0 with sra=1 and rotate=0: logical left
REQ-011 SHALL assert done_valid exactly 1 + shamt[4:2] + shamt[1:0] rising edges after the accept edge, counting the accept edge itself. Maximum latency is 11.
REQ-012 SHALL hold result and done_valid stable in DONE until done_ready is high.
REQ-013 SHALL go from DONE to IDLE on the edge where done_valid and done_ready are both high. There is no accept in that same cycle; the earliest next accept is one cycle later.
REQ-014 SHALL hold result at the last completed value outside DONE; result is only meaningful while done_valid is high.
REQ-015 SHALL ignore done_ready outside DONE and start_valid outside IDLE.

Reset
REQ-016 SHALL, on rst_n low, immediately set:
- state = IDLE
- result = 0, done_valid = 0, busy = 0
- the working register, remaining count and latched controls = 0
REQ-017 SHALL abort an in-flight operation on reset and produce no done_valid for it.
REQ-018 SHALL assert start_ready on the first rising edge after rst_n deasserts.

Structure
REQ-019 SHALL place the FSM state encoding (2 bits), the data-width constant and the shamt-width constant in a shared package, seq_shifter_pkg.
REQ-020 SHALL instantiate one combinational sub-module, shift_step. It takes the working value, op, sra, rotate and a step-size select (4 or 1) and returns the next working value.
REQ-021 SHALL keep the FSM, the remaining counter and the registers in seq_shifter.

Verification
REQ-022 SHALL cover the following directed scenarios in the bench:
- a=12345678, shamt=4, op=0 -> result=23456780, done_valid 2 edges after accept.
- a=87654321, shamt=4, op=1, sra=1 -> result=F8765432; separately a=80000000, shamt=5, op=1, logical -> result=04000000, latency 3.
- a=FEDCBA98, shamt=8, op=1, rotate=1 -> result=98FEDCBA, latency 3; a=00000001, shamt=31, op=0, rotate=1 -> result=80000000, latency 11.
- shamt=0, a=C0FFEE01 -> result=C0FFEE01, done_valid 1 edge after accept; hold done_ready=0 for 5 cycles -> result and done_valid stable, start_ready=0.
- rst_n low during SHIFT4 of a shamt=20 request -> all outputs 0 and state IDLE immediately; after release, a new request completes correctly.
- Back-to-back requests with done_ready tied high -> start_ready drops for exactly the cycles from accept through DONE, and each result matches a software reference model.
